// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the multi-channel LED PWM driver.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_PWM     = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  // Number of prescaler ticks in one PWM frame.
  function automatic int unsigned frame_len(input int unsigned pw);
    return 32'd1 << pw;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: frame-shadowed config, breathe ramp, lit compare and
// the registered, polarity-adjusted pin.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int   PW         = 8,
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          wrap_i,
  input  logic [PW-1:0] pwm_cnt_i,
  input  logic [1:0]    mode_i,
  input  logic [PW-1:0] duty_i,
  output logic          led_o
);

  led_mode_t     mode_q;
  logic [PW-1:0] duty_q;
  logic [PW-1:0] level_q, level_d;
  logic          dir_q, dir_d;    // 0 = ramping up, 1 = ramping down
  logic          lit_s;
  logic          led_q;

  // Breathe ramp advances once per frame against the ceiling already in force.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    if (!enable_i || (mode_q != LED_BREATHE)) begin
      level_d = '0;
      dir_d   = 1'b0;
    end else if (wrap_i) begin
      if (!dir_q) begin
        if (level_q < duty_q) level_d = level_q + 1'b1;
        else                  dir_d   = 1'b1;
      end else begin
        if (level_q != '0) level_d = level_q - 1'b1;
        else               dir_d   = 1'b0;
      end
    end else begin
      level_d = level_q;
    end
  end

  always_comb begin
    case (mode_q)
      LED_OFF:     lit_s = 1'b0;
      LED_ON:      lit_s = 1'b1;
      LED_PWM:     lit_s = pwm_cnt_i < duty_q;
      LED_BREATHE: lit_s = pwm_cnt_i < level_q;
      default:     lit_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= LED_OFF;
      duty_q  <= '0;
      level_q <= '0;
      dir_q   <= 1'b0;
      led_q   <= ACTIVE_LOW;
    end else begin
      // Idle shadows track inputs so the first enabled frame is current.
      if (!enable_i || wrap_i) begin
        mode_q <= led_mode_t'(mode_i);
        duty_q <= duty_i;
      end
      level_q <= level_d;
      dir_q   <= dir_d;
      led_q   <= enable_i ? (lit_s ^ ACTIVE_LOW) : ACTIVE_LOW;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_array.sv
// Multi-channel LED driver: shared prescaler and PWM frame counter feeding
// CH independent channels.
module led_pwm_array
  import led_pwm_pkg::*;
#(
  parameter int             CH         = 6,
  parameter int             PW         = 8,
  parameter int             PSW        = 16,
  parameter logic [CH-1:0]  ACTIVE_LOW = '0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [PSW-1:0]    prescale,
  input  logic [2*CH-1:0]   mode,
  input  logic [PW*CH-1:0]  duty,
  output logic [CH-1:0]     led,
  output logic              frame_start
);

  localparam int unsigned   FRAME   = frame_len(PW);
  localparam logic [PW-1:0] PWM_MAX = PW'(FRAME - 1);

  logic [PSW-1:0] psc_q;
  logic [PW-1:0]  pwm_q;
  logic           fs_q;
  logic           tick_s;
  logic           wrap_s;

  // >= rather than == so lowering prescale below the count never stalls.
  assign tick_s = enable && (psc_q >= prescale);
  assign wrap_s = tick_s && (pwm_q == PWM_MAX);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      psc_q <= '0;
      pwm_q <= '0;
      fs_q  <= 1'b0;
    end else if (!enable) begin
      psc_q <= '0;
      pwm_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      psc_q <= tick_s ? '0 : psc_q + 1'b1;
      if (tick_s) pwm_q <= pwm_q + 1'b1;
      fs_q  <= wrap_s;
    end
  end

  assign frame_start = fs_q;

  for (genvar gc = 0; gc < CH; gc++) begin : g_ch
    led_pwm_channel #(
      .PW         (PW),
      .ACTIVE_LOW (ACTIVE_LOW[gc])
    ) u_ch (
      .clk       (aclk),
      .rst       (areset),
      .enable_i  (enable),
      .wrap_i    (wrap_s),
      .pwm_cnt_i (pwm_q),
      .mode_i    (mode[2*gc +: 2]),
      .duty_i    (duty[PW*gc +: PW]),
      .led_o     (led[gc])
    );
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed self-checking bench for led_pwm_array (CH=6, PW=8, ch0/1/5 active-low).
module tb_led_pwm_array;

  localparam int          CH = 6;
  localparam int          PW = 8;
  localparam logic [5:0]  AL = 6'b100011;

  logic         aclk = 1'b0;
  logic         areset;
  logic         enable;
  logic [15:0]  prescale;
  logic [11:0]  mode;
  logic [47:0]  duty;
  logic [5:0]   led;
  logic         frame_start;

  int checks = 0;
  int errors = 0;
  int lit_cnt [CH];
  int fs_cnt;

  led_pwm_array #(.CH(CH), .PW(PW), .PSW(16), .ACTIVE_LOW(AL)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .prescale(prescale),
    .mode(mode), .duty(duty), .led(led), .frame_start(frame_start)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [1:0] m, input logic [7:0] d);
    mode[2*c +: 2] = m;
    duty[8*c +: 8] = d;
  endtask

  task automatic clear_cnt();
    for (int c = 0; c < CH; c++) lit_cnt[c] = 0;
    fs_cnt = 0;
  endtask

  task automatic sample_acc();
    for (int c = 0; c < CH; c++) lit_cnt[c] += int'(led[c] ^ AL[c]);
    fs_cnt += int'(frame_start);
  endtask

  // Disable for one edge (counters cleared, shadows loaded), then re-enable.
  task automatic restart();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  // Count n samples; optionally reconfigure channel c after sample 'at'.
  task automatic window(input int n, input int at, input int c,
                        input logic [1:0] m, input logic [7:0] d);
    clear_cnt();
    for (int i = 0; i < n; i++) begin
      step();
      sample_acc();
      if (i == at) set_ch(c, m, d);
    end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 5000; i++) begin
      step();
      if (frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_fs: no frame_start within 5000 cycles");
  endtask

  task automatic measure_frame(output int len);
    wait_fs();
    clear_cnt();
    len = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      len++;
      sample_acc();
      if (frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL measure_frame: frame did not end within 5000 cycles");
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    int         exp_lit;
  } vec_t;

  vec_t vecs [7];
  int   breathe_exp [10];
  int   len;

  initial begin
    vecs[0] = '{m: 2'd2, d: 8'd64,  exp_lit: 64};
    vecs[1] = '{m: 2'd2, d: 8'd0,   exp_lit: 0};
    vecs[2] = '{m: 2'd2, d: 8'd255, exp_lit: 255};
    vecs[3] = '{m: 2'd2, d: 8'd1,   exp_lit: 1};
    vecs[4] = '{m: 2'd2, d: 8'd128, exp_lit: 128};
    vecs[5] = '{m: 2'd1, d: 8'd17,  exp_lit: 256};
    vecs[6] = '{m: 2'd0, d: 8'd200, exp_lit: 0};
    breathe_exp = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};

    areset   = 1'b1;
    enable   = 1'b0;
    prescale = 16'd0;
    mode     = 12'd0;
    duty     = 48'd0;
    #22;
    chk("reset_led", int'(led), int'(AL));
    chk("reset_fs", int'(frame_start), 0);
    areset = 1'b0;
    step();
    chk("idle_led", int'(led), int'(AL));

    // Fixed-duty table on ch0, one full frame each, prescale 0.
    for (int v = 0; v < 7; v++) begin
      set_ch(0, vecs[v].m, vecs[v].d);
      restart();
      window(256, -1, 0, 2'd0, 8'd0);
      chk($sformatf("tbl%0d_lit", v), lit_cnt[0], vecs[v].exp_lit);
      chk($sformatf("tbl%0d_fs", v), fs_cnt, 1);
    end

    // Prescale 3: four cycles per tick.
    prescale = 16'd3;
    set_ch(0, 2'd2, 8'd64);
    restart();
    measure_frame(len);
    chk("psc3_frame_len", len, 1024);
    chk("psc3_lit", lit_cnt[0], 256);

    // Prescale drops from 1000 to 2 while the count sits at 500.
    prescale = 16'd1000;
    set_ch(0, 2'd2, 8'd1);
    restart();
    for (int i = 0; i < 500; i++) step();
    chk("psc_drop_pre", int'(led[0] ^ AL[0]), 1);
    prescale = 16'd2;
    step();
    chk("psc_drop_edge0", int'(led[0] ^ AL[0]), 1);
    step();
    chk("psc_drop_edge1", int'(led[0] ^ AL[0]), 0);
    measure_frame(len);
    chk("psc2_frame_len", len, 768);
    chk("psc2_lit", lit_cnt[0], 3);

    // Mid-frame config changes are deferred to the next wrap.
    prescale = 16'd0;
    set_ch(0, 2'd0, 8'd0);
    set_ch(1, 2'd2, 8'd32);
    restart();
    wait_fs();
    window(256, 100, 1, 2'd2, 8'd200);
    chk("shadow_duty_cur", lit_cnt[1], 32);
    set_ch(1, 2'd1, 8'd200);
    window(256, -1, 0, 2'd0, 8'd0);
    chk("shadow_duty_next", lit_cnt[1], 200);
    window(256, 50, 1, 2'd0, 8'd200);
    chk("shadow_on_cur", lit_cnt[1], 256);
    window(256, -1, 0, 2'd0, 8'd0);
    chk("shadow_off_next", lit_cnt[1], 0);

    // Breathe with ceiling 3, then a detour through PWM.
    set_ch(1, 2'd0, 8'd0);
    set_ch(2, 2'd3, 8'd3);
    restart();
    for (int f = 0; f < 10; f++) begin
      window(256, -1, 0, 2'd0, 8'd0);
      chk($sformatf("breathe_f%0d", f), lit_cnt[2], breathe_exp[f]);
    end
    window(256, 10, 2, 2'd2, 8'd3);
    chk("breathe_f10", lit_cnt[2], 2);
    window(256, 10, 2, 2'd3, 8'd3);
    chk("breathe_pwm_frame", lit_cnt[2], 3);
    window(256, -1, 0, 2'd0, 8'd0);
    chk("breathe_resume0", lit_cnt[2], 0);
    window(256, -1, 0, 2'd0, 8'd0);
    chk("breathe_resume1", lit_cnt[2], 1);

    // Mixed modes against a closed-form reference, cycle by cycle.
    set_ch(0, 2'd0, 8'd10);
    set_ch(1, 2'd1, 8'd20);
    set_ch(2, 2'd2, 8'd64);
    set_ch(3, 2'd2, 8'd200);
    set_ch(4, 2'd3, 8'd5);
    set_ch(5, 2'd2, 8'd128);
    restart();
    for (int k = 0; k < 2560; k++) begin
      int f, p, q, lvl;
      logic [5:0] lit;
      step();
      f   = k / 256;
      p   = k % 256;
      q   = f % 12;
      lvl = (q <= 5) ? q : 11 - q;
      lit = {p < 128, p < lvl, p < 200, p < 64, 1'b1, 1'b0};
      chk($sformatf("mixed_led_k%0d", k), int'(led), int'(lit ^ AL));
      chk($sformatf("mixed_fs_k%0d", k), int'(frame_start), int'(p == 255));
    end

    enable = 1'b0;
    step();
    chk("disable_led", int'(led), int'(AL));
    chk("disable_fs", int'(frame_start), 0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("run_ch1_on", int'(led[1]), 0);

    // Asynchronous reset in the middle of a clock period.
    #2;
    areset = 1'b1;
    #1;
    chk("async_reset_led", int'(led), int'(AL));
    chk("async_reset_fs", int'(frame_start), 0);
    #3;
    areset = 1'b0;
    enable = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (led !== AL || frame_start !== 1'b0) bad++;
      end
      chk("idle_1000_deviations", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
